e_mdu: RTL and testbench

E_MDU -- requirements
Module: e_mdu

---
 rtl/e_mdu.sv | 174 +++++++++++++++++
 tb/tb_e_mdu.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/e_mdu.sv
// E-stage multiply/divide unit: computes the product or quotient/remainder
// at issue into staging registers, then commits them to HI/LO after a fixed
// multi-cycle latency (5 cycles mult, 10 cycles div). mthi/mtlo write HI/LO
// directly; mfhi/mflo read them combinationally.
module e_mdu (
    input  logic        clk,
    input  logic        reset,
    input  logic        Req,
    input  logic [3:0]  HILOtype,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Start,
    output logic        Busy,
    output logic [31:0] MDU_Out,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MFHI  = 4'd5,
        OP_MFLO  = 4'd6,
        OP_MTHI  = 4'd7,
        OP_MTLO  = 4'd8
    } hilo_op_e;

    localparam logic [3:0] MUL_CYCLES = 4'd5;
    localparam logic [3:0] DIV_CYCLES = 4'd10;

    hilo_op_e    op;
    logic        is_mul;
    logic        is_div;
    logic        is_signed;
    logic        div_by_zero;

    logic [3:0]  cnt;
    logic [31:0] t_hi;
    logic [31:0] t_lo;
    logic        commit_ok;

    logic [63:0] product;
    logic [31:0] num_mag;
    logic [31:0] den_mag;
    logic [31:0] quo_mag;
    logic [31:0] rem_mag;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic [31:0] res_hi;
    logic [31:0] res_lo;

    assign op = hilo_op_e'(HILOtype);

    // Decode the requested operation class
    always_comb begin
        is_mul    = 1'b0;
        is_div    = 1'b0;
        is_signed = 1'b0;
        case (op)
            OP_MULT: begin
                is_mul    = 1'b1;
                is_signed = 1'b1;
            end
            OP_MULTU: is_mul = 1'b1;
            OP_DIV: begin
                is_div    = 1'b1;
                is_signed = 1'b1;
            end
            OP_DIVU: is_div = 1'b1;
            default: ;
        endcase
    end

    // Issue handshake: blocked by flush, an op in flight, or reset
    always_comb begin
        Start = reset & ~Req & ~Busy & (is_mul | is_div);
    end

    // 64-bit product, sign-extended operands for mult, zero-extended for multu
    always_comb begin
        if (is_signed) begin
            product = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
        end else begin
            product = {32'd0, A} * {32'd0, B};
        end
    end

    // Divide on magnitudes and fix signs afterwards; this gives truncation
    // toward zero, a remainder carrying the dividend's sign, and makes
    // 0x80000000 / -1 fall out as 0x80000000 rem 0 without a special case.
    // A zero divisor is replaced by 1 only to keep the arithmetic defined;
    // the result is never committed in that case.
    always_comb begin
        div_by_zero = (B == '0);
        if (is_signed) begin
            num_mag = A[31] ? (~A + 32'd1) : A;
            den_mag = B[31] ? (~B + 32'd1) : B;
        end else begin
            num_mag = A;
            den_mag = B;
        end
        if (div_by_zero) begin
            den_mag = 32'd1;
        end
        quo_mag   = num_mag / den_mag;
        rem_mag   = num_mag % den_mag;
        quotient  = quo_mag;
        remainder = rem_mag;
        if (is_signed && (A[31] ^ B[31])) begin
            quotient = ~quo_mag + 32'd1;
        end
        if (is_signed && A[31]) begin
            remainder = ~rem_mag + 32'd1;
        end
    end

    // Select the value to stage for HI/LO
    always_comb begin
        if (is_div) begin
            res_hi = remainder;
            res_lo = quotient;
        end else begin
            res_hi = product[63:32];
            res_lo = product[31:0];
        end
    end

    // Read port for mfhi/mflo, independent of Req and Busy
    always_comb begin
        case (op)
            OP_MFHI: MDU_Out = HI;
            OP_MFLO: MDU_Out = LO;
            default: MDU_Out = '0;
        endcase
    end

    // Latency counter, staging registers and architectural HI/LO
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt       <= '0;
            Busy      <= 1'b0;
            t_hi      <= '0;
            t_lo      <= '0;
            commit_ok <= 1'b0;
            HI        <= '0;
            LO        <= '0;
        end else if (Start) begin
            cnt       <= is_div ? DIV_CYCLES : MUL_CYCLES;
            Busy      <= 1'b1;
            t_hi      <= res_hi;
            t_lo      <= res_lo;
            commit_ok <= ~(is_div & div_by_zero);
        end else if (cnt != '0) begin
            cnt <= cnt - 4'd1;
            if (cnt == 4'd1) begin
                Busy <= 1'b0;
                if (commit_ok) begin
                    HI <= t_hi;
                    LO <= t_lo;
                end
            end
        end else if (!Req) begin
            if (op == OP_MTHI) begin
                HI <= A;
            end else if (op == OP_MTLO) begin
                LO <= A;
            end
        end
    end

endmodule

// File: tb/tb_e_mdu.sv
// Directed testbench for e_mdu: each task drives one scenario and checks
// outputs against hand-computed values. Inputs change 1ns after the rising
// edge; outputs are sampled in the same window.
module tb_e_mdu;

    logic        clk;
    logic        reset;
    logic        Req;
    logic [3:0]  HILOtype;
    logic [31:0] A;
    logic [31:0] B;
    logic        Start;
    logic        Busy;
    logic [31:0] MDU_Out;
    logic [31:0] HI;
    logic [31:0] LO;

    int compared;
    int mismatched;

    e_mdu dut (
        .clk      (clk),
        .reset    (reset),
        .Req      (Req),
        .HILOtype (HILOtype),
        .A        (A),
        .B        (B),
        .Start    (Start),
        .Busy     (Busy),
        .MDU_Out  (MDU_Out),
        .HI       (HI),
        .LO       (LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic rq);
        HILOtype = op;
        A        = a;
        B        = b;
        Req      = rq;
        #1;
    endtask

    // Counts cycles Busy stays high, bounded so a stuck Busy cannot hang
    task automatic wait_idle(output int n);
        n = 0;
        while (Busy === 1'b1 && n < 40) begin
            n++;
            tick();
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        drive(4'd1, 32'd3, 32'd4, 1'b0);
        tick();
        tick();
        compared++;
        if (HI !== 32'd0) begin mismatched++; $display("FAIL reset_hi: got %h want %h", HI, 32'd0); end
        compared++;
        if (LO !== 32'd0) begin mismatched++; $display("FAIL reset_lo: got %h want %h", LO, 32'd0); end
        compared++;
        if (Busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy: got %b want 0", Busy); end
        compared++;
        if (Start !== 1'b0) begin mismatched++; $display("FAIL reset_start: got %b want 0", Start); end
        drive(4'd0, 32'd0, 32'd0, 1'b0);
        reset = 1'b1;
        tick();
    endtask

    task automatic test_mult();
        int n;
        drive(4'd1, 32'hFFFF_FFFE, 32'd3, 1'b0);
        compared++;
        if (Start !== 1'b1) begin mismatched++; $display("FAIL mult_start: got %b want 1", Start); end
        tick();
        drive(4'd0, 32'd0, 32'd0, 1'b0);
        compared++;
        if (Busy !== 1'b1) begin mismatched++; $display("FAIL mult_busy: got %b want 1", Busy); end
        compared++;
        if (HI !== 32'd0) begin mismatched++; $display("FAIL mult_hi_precommit: got %h want %h", HI, 32'd0); end
        wait_idle(n);
        compared++;
        if (n != 5) begin mismatched++; $display("FAIL mult_latency: got %0d want 5", n); end
        compared++;
        if (HI !== 32'hFFFF_FFFF) begin mismatched++; $display("FAIL mult_hi: got %h want %h", HI, 32'hFFFF_FFFF); end
        compared++;
        if (LO !== 32'hFFFF_FFFA) begin mismatched++; $display("FAIL mult_lo: got %h want %h", LO, 32'hFFFF_FFFA); end
    endtask

    task automatic test_multu_back_to_back();
        int n;
        drive(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        tick();
        drive(4'd0, 32'd0, 32'd0, 1'b0);
        wait_idle(n);
        compared++;
        if (n != 5) begin mismatched++; $display("FAIL multu_latency: got %0d want 5", n); end
        compared++;
        if (HI !== 32'hFFFF_FFFE) begin mismatched++; $display("FAIL multu_hi: got %h want %h", HI, 32'hFFFF_FFFE); end
        compared++;
        if (LO !== 32'h0000_0001) begin mismatched++; $display("FAIL multu_lo: got %h want %h", LO, 32'h1); end
        // Issue immediately in the first idle cycle
        drive(4'd1, 32'h0001_0000, 32'hFFFF_0000, 1'b0);
        compared++;
        if (Start !== 1'b1) begin mismatched++; $display("FAIL b2b_start: got %b want 1", Start); end
        tick();
        drive(4'd0, 32'd0, 32'd0, 1'b0);
        wait_idle(n);
        compared++;
        if (n != 5) begin mismatched++; $display("FAIL b2b_latency: got %0d want 5", n); end
        compared++;
        if (HI !== 32'hFFFF_FFFF) begin mismatched++; $display("FAIL b2b_hi: got %h want %h", HI, 32'hFFFF_FFFF); end
        compared++;
        if (LO !== 32'h0000_0000) begin mismatched++; $display("FAIL b2b_lo: got %h want %h", LO, 32'h0); end
    endtask

    task automatic test_div();
        int n;
        drive(4'd4, 32'd7, 32'd2, 1'b0);
        tick();
        drive(4'd0, 32'd0, 32'd0, 1'b0);
        wait_idle(n);
        compared++;
        if (n != 10) begin mismatched++; $display("FAIL divu_latency: got %0d want 10", n); end
        compared++;
        if (LO !== 32'd3) begin mismatched++; $display("FAIL divu_lo: got %h want %h", LO, 32'd3); end
        compared++;
        if (HI !== 32'd1) begin mismatched++; $display("FAIL divu_hi: got %h want %h", HI, 32'd1); end

        drive(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
        tick();
        drive(4'd0, 32'd0, 32'd0, 1'b0);
        wait_idle(n);
        compared++;
        if (n != 10) begin mismatched++; $display("FAIL div_latency: got %0d want 10", n); end
        compared++;
        if (LO !== 32'hFFFF_FFFD) begin mismatched++; $display("FAIL div_neg_lo: got %h want %h", LO, 32'hFFFF_FFFD); end
        compared++;
        if (HI !== 32'hFFFF_FFFF) begin mismatched++; $display("FAIL div_neg_hi: got %h want %h", HI, 32'hFFFF_FFFF); end

        drive(4'd3, 32'd7, 32'hFFFF_FFFE, 1'b0);
        tick();
        drive(4'd0, 32'd0, 32'd0, 1'b0);
        wait_idle(n);
        compared++;
        if (LO !== 32'hFFFF_FFFD) begin mismatched++; $display("FAIL div_negdiv_lo: got %h want %h", LO, 32'hFFFF_FFFD); end
        compared++;
        if (HI !== 32'd1) begin mismatched++; $display("FAIL div_negdiv_hi: got %h want %h", HI, 32'd1); end

        drive(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        tick();
        drive(4'd0, 32'd0, 32'd0, 1'b0);
        wait_idle(n);
        compared++;
        if (LO !== 32'h8000_0000) begin mismatched++; $display("FAIL div_ovf_lo: got %h want %h", LO, 32'h8000_0000); end
        compared++;
        if (HI !== 32'd0) begin mismatched++; $display("FAIL div_ovf_hi: got %h want %h", HI, 32'd0); end
    endtask

    task automatic test_mthi_mtlo();
        drive(4'd7, 32'h1234_5678, 32'd0, 1'b1);
        tick();
        compared++;
        if (HI !== 32'd0) begin mismatched++; $display("FAIL mthi_req_hi: got %h want %h", HI, 32'd0); end
        drive(4'd7, 32'h1234_5678, 32'd0, 1'b0);
        compared++;
        if (Start !== 1'b0) begin mismatched++; $display("FAIL mthi_start: got %b want 0", Start); end
        tick();
        compared++;
        if (Busy !== 1'b0) begin mismatched++; $display("FAIL mthi_busy: got %b want 0", Busy); end
        drive(4'd5, 32'd0, 32'd0, 1'b1);
        compared++;
        if (MDU_Out !== 32'h1234_5678) begin mismatched++; $display("FAIL mfhi_out: got %h want %h", MDU_Out, 32'h1234_5678); end
        drive(4'd8, 32'hCAFE_F00D, 32'd0, 1'b0);
        tick();
        drive(4'd6, 32'd0, 32'd0, 1'b0);
        compared++;
        if (MDU_Out !== 32'hCAFE_F00D) begin mismatched++; $display("FAIL mflo_out: got %h want %h", MDU_Out, 32'hCAFE_F00D); end
        drive(4'd12, 32'd0, 32'd0, 1'b0);
        compared++;
        if (MDU_Out !== 32'd0) begin mismatched++; $display("FAIL mdu_out_none: got %h want %h", MDU_Out, 32'd0); end
        // Flush must also suppress a multiply issue
        drive(4'd1, 32'd2, 32'd2, 1'b1);
        compared++;
        if (Start !== 1'b0) begin mismatched++; $display("FAIL req_start: got %b want 0", Start); end
        tick();
        compared++;
        if (Busy !== 1'b0) begin mismatched++; $display("FAIL req_busy: got %b want 0", Busy); end
        drive(4'd0, 32'd0, 32'd0, 1'b0);
    endtask

    task automatic test_divzero_ignore();
        int n;
        drive(4'd7, 32'd5, 32'd0, 1'b0);
        tick();
        drive(4'd8, 32'd6, 32'd0, 1'b0);
        tick();
        drive(4'd3, 32'd9, 32'd0, 1'b0);
        tick();
        drive(4'd0, 32'd0, 32'd0, 1'b0);
        n = 0;
        while (Busy === 1'b1 && n < 40) begin
            n++;
            if (n == 3) begin
                drive(4'd2, 32'd100, 32'd100, 1'b0);
                compared++;
                if (Start !== 1'b0) begin mismatched++; $display("FAIL busy_multu_start: got %b want 0", Start); end
            end else if (n == 4) begin
                drive(4'd7, 32'hDEAD_BEEF, 32'd0, 1'b0);
            end else if (n == 5) begin
                drive(4'd5, 32'd0, 32'd0, 1'b0);
                compared++;
                if (MDU_Out !== 32'd5) begin mismatched++; $display("FAIL busy_mfhi: got %h want %h", MDU_Out, 32'd5); end
            end else begin
                drive(4'd0, 32'd0, 32'd0, 1'b0);
            end
            tick();
        end
        drive(4'd0, 32'd0, 32'd0, 1'b0);
        compared++;
        if (n != 10) begin mismatched++; $display("FAIL divzero_latency: got %0d want 10", n); end
        compared++;
        if (HI !== 32'd5) begin mismatched++; $display("FAIL divzero_hi: got %h want %h", HI, 32'd5); end
        compared++;
        if (LO !== 32'd6) begin mismatched++; $display("FAIL divzero_lo: got %h want %h", LO, 32'd6); end
        tick();
        compared++;
        if (Busy !== 1'b0) begin mismatched++; $display("FAIL no_queue_busy: got %b want 0", Busy); end
    endtask

    task automatic test_reset_abort();
        int n;
        drive(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        tick();
        drive(4'd0, 32'd0, 32'd0, 1'b0);
        tick();
        reset = 1'b0;
        #1;
        compared++;
        if (HI !== 32'd0) begin mismatched++; $display("FAIL abort_hi: got %h want %h", HI, 32'd0); end
        compared++;
        if (LO !== 32'd0) begin mismatched++; $display("FAIL abort_lo: got %h want %h", LO, 32'd0); end
        compared++;
        if (Busy !== 1'b0) begin mismatched++; $display("FAIL abort_busy: got %b want 0", Busy); end
        tick();
        reset = 1'b1;
        for (int i = 0; i < 12; i++) tick();
        compared++;
        if (HI !== 32'd0 || LO !== 32'd0) begin
            mismatched++;
            $display("FAIL abort_no_commit: got %h_%h want %h_%h", HI, LO, 32'd0, 32'd0);
        end
        // First edge after release must accept an issue
        reset = 1'b0;
        tick();
        reset = 1'b1;
        drive(4'd1, 32'd6, 32'd7, 1'b0);
        compared++;
        if (Start !== 1'b1) begin mismatched++; $display("FAIL post_reset_start: got %b want 1", Start); end
        tick();
        drive(4'd0, 32'd0, 32'd0, 1'b0);
        compared++;
        if (Busy !== 1'b1) begin mismatched++; $display("FAIL post_reset_busy: got %b want 1", Busy); end
        wait_idle(n);
        compared++;
        if (LO !== 32'd42) begin mismatched++; $display("FAIL post_reset_lo: got %h want %h", LO, 32'd42); end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        reset      = 1'b0;
        Req        = 1'b0;
        HILOtype   = 4'd0;
        A          = 32'd0;
        B          = 32'd0;
        #1;
        test_reset();
        test_mult();
        test_multu_back_to_back();
        test_div();
        // Clear HI/LO so the mthi checks start from a known zero
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        test_mthi_mtlo();
        test_divzero_ignore();
        test_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
